// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM encoding and
// bit-counter sizing.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Counter width for a given operand width; must hold WIDTH-1.
    function automatic int calc_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// The shared 1-bit full adder cell that the sequencer time-shares.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: steps one full_adder LSB-first with a registered carry.
// Optional subtraction via macro SERIAL_ADDER_SUB_EN (adds a 'sub' input).
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int            CW       = calc_cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_r, state_s;
    logic             busy_r, done_r, cout_r, carry_r;
    logic             busy_s, done_s, accept_s, shift_s, last_s;
    logic [WIDTH-1:0] result_r, a_sh_r, b_sh_r;
    logic [CW-1:0]    cnt_r;
    logic             sum_s, carry_out_s;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_load_s;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtraction: invert B and inject a carry of one.
    assign b_load_s     = sub ? ~b_in : b_in;
    assign carry_load_s = sub;
`else
    assign b_load_s     = b_in;
    assign carry_load_s = 1'b0;
`endif

    full_adder u_fa (
        .A    (a_sh_r[0]),
        .B    (b_sh_r[0]),
        .Cin  (carry_r),
        .S    (sum_s),
        .Cout (carry_out_s)
    );

    // Next-state decode plus next values of the registered busy/done flags.
    always_comb begin
        state_s  = state_r;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        accept_s = 1'b0;
        shift_s  = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_SHIFT;
                    busy_s   = 1'b1;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    last_s  = 1'b1;
                    done_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    busy_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and handshake flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Operand capture, serial shifting, carry chain and result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
        end else if (accept_s) begin
            a_sh_r  <= a_in;
            b_sh_r  <= b_load_s;
            carry_r <= carry_load_s;
            cnt_r   <= '0;
        end else if (shift_s) begin
            carry_r  <= carry_out_s;
            result_r <= {sum_s, result_r[WIDTH-1:1]};
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + CW'(1);
            if (last_s) begin
                cout_r <= carry_out_s;
            end else begin
                cout_r <= cout_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign cout   = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an 8-bit instance for directed cases and
// a 4-bit instance for the exhaustive back-to-back sweep.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start4;
    logic [7:0] a8, b8, result8;
    logic [3:0] a4, b4, result4;
    logic       busy8, done8, cout8, busy4, done4, cout4;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8, sub4;
`endif

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .a_in(a8), .b_in(b8), .busy(busy8), .done(done8),
        .result(result8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub4),
`endif
        .a_in(a4), .b_in(b4), .busy(busy4), .done(done4),
        .result(result4), .cout(cout4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon8
        logic [8:0] e;
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                check_eq("sb8_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                check_eq("sb8_sum", {55'd0, cout8, result8}, {55'd0, e});
            end
        end
    end

    always @(negedge clk) begin : mon4
        logic [4:0] e;
        if (rst_n && done4) begin
            if (q4.size() == 0) begin
                check_eq("sb4_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q4.pop_front();
                check_eq("sb4_sum", {59'd0, cout4, result4}, {59'd0, e});
            end
        end
    end

    // One 8-bit operation; optionally hold start high and disturb operands mid-SHIFT.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s,
                       input bit hold, input bit mutate);
        int busy_n, done_n, lat;
        busy_n = 0;
        done_n = 0;
        lat    = -1;
        @(negedge clk);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = s;
`endif
        if (s) q8.push_back({1'b0, a} + {1'b0, ~b} + 9'd1);
        else   q8.push_back({1'b0, a} + {1'b0, b});
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!hold) start8 = 1'b0;
            if (mutate && k == 3) begin
                a8 = ~a8;
                b8 = b8 + 8'd77;
            end
            if (busy8) busy_n++;
            if (done8) begin
                done_n++;
                if (lat < 0) lat = k;
                start8 = 1'b0;
            end
            if (lat >= 0 && k >= lat + 6) break;
        end
        start8 = 1'b0;
        check_eq("lat8", 64'(lat), 64'd8);
        check_eq("busy8_cycles", 64'(busy_n), 64'd8);
        check_eq("done8_pulses", 64'(done_n), 64'd1);
    endtask

    // All 4-bit operand pairs with start held high between operations.
    task automatic sweep4();
        int  last_done;
        bit  got;
        last_done = 0;
        @(negedge clk);
        start4 = 1'b1;
        a4 = 4'd0;
        b4 = 4'd0;
        q4.push_back(5'd0);
        for (int i = 0; i < 256; i++) begin
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (done4) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                check_eq("done4_timeout", 64'd0, 64'd1);
                break;
            end
            if (i > 0) check_eq("done4_spacing", 64'(cyc - last_done), 64'd6);
            last_done = cyc;
            if (i < 255) begin
                a4 = 4'(i + 1);
                b4 = 4'((i + 1) >> 4);
                q4.push_back({1'b0, a4} + {1'b0, b4});
            end else begin
                start4 = 1'b0;
            end
        end
        start4 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int extra;
        rst_n  = 1'b0;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; a4 = 4'd0; b4 = 4'd0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
        sub4 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_eq("rst8_outs", {60'd0, busy8, done8, cout8, |result8}, 64'd0);
        check_eq("rst4_outs", {60'd0, busy4, done4, cout4, |result4}, 64'd0);
        rst_n = 1'b1;

        op8(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
        check_eq("tp_05_03", {55'd0, cout8, result8}, 64'h008);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        check_eq("tp_ff_01", {55'd0, cout8, result8}, 64'h100);
        op8(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("tp_aa_55_held", {55'd0, cout8, result8}, 64'h0FF);
        op8(8'h3C, 8'h4D, 1'b0, 1'b1, 1'b1);
        check_eq("tp_hold_mutate", {55'd0, cout8, result8}, 64'h089);

        // Abort in the fourth SHIFT cycle.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h37; b8 = 8'h21;
        q8.push_back(9'h058);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_abort_busy", {63'd0, busy8}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_outs", {60'd0, busy8, done8, cout8, |result8}, 64'd0);
        void'(q8.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) extra++;
        end
        check_eq("abort_no_done", 64'(extra), 64'd0);
        op8(8'h37, 8'h21, 1'b0, 1'b0, 1'b0);
        check_eq("post_abort", {55'd0, cout8, result8}, 64'h058);

        sweep4();

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'h05, 8'h03, 1'b1, 1'b0, 1'b0);
        check_eq("sub_05_03", {55'd0, cout8, result8}, 64'h102);
        op8(8'h03, 8'h05, 1'b1, 1'b0, 1'b0);
        check_eq("sub_03_05", {55'd0, cout8, result8}, 64'h0FE);
        sub8 = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check_eq("sb8_drained", 64'(q8.size()), 64'd0);
        check_eq("sb4_drained", 64'(q4.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that time-shares one existing 1-bit full_adder cell to add two WIDTH-bit operands bit-serially, LSB first.
- Accepts a start/operand handshake, steps the full adder for WIDTH cycles with a registered carry, and returns the sum, carry-out and a one-cycle done pulse.
- Sits between a requester (ALU front end or bench) and the shared full_adder instance.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A, captured when start is accepted.
- b_in  input  WIDTH  operand B, captured when start is accepted.
- busy  output  1  high while the operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse when result and cout are valid.
- result  output  WIDTH  sum; held stable from the done pulse until the next accepted start.
- cout  output  1  final carry-out; held with result.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, result=0, cout=0; shift registers, carry register and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at a clock edge moves the FSM to SHIFT (the accept edge, cycle 0). On that edge:
  - a_sh<=a_in, b_sh<=b_in.
  - carry<=0.
  - cnt<=0.
- SHIFT, each cycle:
  - full_adder inputs: A=a_sh[0], B=b_sh[0], Cin=carry.
  - On the edge: carry<=Cout; result shifts right with S entering at bit WIDTH-1; a_sh and b_sh shift right; cnt<=cnt+1.
  - When cnt==WIDTH-1 on an edge: go to DONE; cout<=final Cout.
- DONE: done=1 for exactly one cycle, busy=0, then unconditionally return to IDLE.
- Latency: an accept at edge 0 gives done=1 in the cycle after edge WIDTH. result and cout are valid from that cycle onward.
- busy=1 exactly in SHIFT, for WIDTH cycles.
- start is ignored in SHIFT and DONE. No queuing; the requester must wait for done and then re-assert start.
- Back-to-back operation: the earliest next accept is the edge after the DONE cycle. Throughput is one operation per WIDTH+2 cycles.
- result is only written by shift activity. While the FSM is in IDLE it holds the last sum.
- Reset asserted during SHIFT aborts the operation immediately: no done pulse, and outputs return to their reset values.
- Arithmetic: result = (a_in + b_in) mod 2^WIDTH; cout = bit WIDTH of the full sum.
- The carry register is internal. No combinational path from start, a_in or b_in to any output.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Extra input port sub (1 bit), sampled together with start.
  - If sub=1: b_sh<=~b_in and carry<=1 at accept, so result=(a_in-b_in) mod 2^WIDTH.
  - cout=1 means no borrow (a_in>=b_in unsigned).
  - If sub=0: behaviour is identical to the addition case above.
- When not defined: no sub port, addition only. Port list and timing are otherwise identical.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Counter width constant CNT_W=$clog2(WIDTH).
- Sub-module: the existing full_adder (ports A, B, Cin, S, Cout), instantiated once as the only arithmetic element.
- No adder logic is written inline in the controller.

Test Plan:
- WIDTH=8, a_in=0x05, b_in=0x03, start 1 cycle -> busy high 8 cycles, done pulse at cycle 9, result=0x08, cout=0.
- a_in=0xFF, b_in=0x01 -> result=0x00, cout=1; a_in=0xAA, b_in=0x55 -> result=0xFF, cout=0.
- start held high for the whole operation, and operands changed mid-SHIFT -> only one done pulse; result reflects the operands captured at accept.
- rst_n pulsed low at SHIFT cycle 4 -> busy, done, result and cout = 0 immediately, no done pulse; a new start afterwards completes correctly.
- Exhaustive sweep of all 4-bit a/b pairs at WIDTH=4 against a behavioural model -> zero mismatches; done spacing = 6 cycles when start is re-asserted immediately.
- With SERIAL_ADDER_SUB_EN, sub=1, a=0x05, b=0x03 -> result=0x02, cout=1; a=0x03, b=0x05 -> result=0xFE, cout=0.
